// File: rtl/dff_skid_slice.sv
// -----------------------------------------------------------------------------
// dff_skid_slice
//
// Consumer-side register slice for a valid/ready stream. Two flop entries
// (main + skid) sustain one beat per cycle while in_ready stays a pure flop
// output, so no combinational path runs from out_ready back to in_ready.
// Ordering is strict FIFO: the skid entry always holds the younger beat.
//
// Parameters:
//   Width      payload width
//   ResetData  value held by both data entries during reset
//
// Ports:
//   CLK        clock, all state on rising edge
//   RSTN       asynchronous active-low reset
//   flush      synchronous clear of both entries (data keeps stale values)
//   in_valid   upstream beat valid
//   in_data    upstream payload
//   in_ready   slice can accept (registered)
//   out_valid  main entry holds a beat (registered)
//   out_data   main entry payload (registered)
//   out_ready  downstream accepts
//   occupancy  number of entries held, 0..2
//
// Optional build macro:
//   DFF_SKID_SLICE_XCHECK_EN  adds a simulation-only X/Z and input-stability
//                             checker; excluded whenever SYNTHESIS is defined.
// -----------------------------------------------------------------------------
module dff_skid_slice #(
  parameter int unsigned      Width     = 8,
  parameter logic [Width-1:0] ResetData = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [Width-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [Width-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // The state encoding is the occupancy count itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;

  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: begin
        // Occupancy 3 is unreachable; recover to a clean empty slice.
        state_d = EMPTY;
      end
    endcase

    // flush overrides everything: an incoming beat is dropped (no load), a
    // departing beat still counts as consumed, and the data flops stay stale.
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);

    main_d = main_q;
    if (main_load) begin
      main_d = main_from_skid ? skid_q : in_data;
    end

    skid_d = skid_q;
    if (skid_load) begin
      skid_d = in_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= ResetData;
      skid_q      <= ResetData;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef DFF_SKID_SLICE_XCHECK_EN
`ifndef SYNTHESIS
  logic [Width-1:0] xc_data_prev;
  logic             xc_stall_prev;

  always @(posedge CLK) begin
    if (RSTN === 1'b1 && ($isunknown(out_valid_q) || $isunknown(in_ready_q)))
      $error("dff_skid_slice: X/Z on out_valid or in_ready");
    if (out_valid_q === 1'b1 && $isunknown(main_q))
      $error("dff_skid_slice: X/Z on out_data while out_valid");
    if (in_fire === 1'b1 && $isunknown(in_data))
      $error("dff_skid_slice: X/Z on in_data at in_fire");
    // A stalled beat must be presented unchanged until it is accepted.
    if (xc_stall_prev === 1'b1 && in_valid === 1'b1 && in_data !== xc_data_prev)
      $error("dff_skid_slice: in_data changed while stalled");
    xc_stall_prev <= RSTN & in_valid & ~in_ready_q;
    xc_data_prev  <= in_data;
  end
`endif
`endif

endmodule

// File: tb/tb_dff_skid_slice.sv
module tb_dff_skid_slice;

  localparam int         W     = 8;
  localparam logic [7:0] RDATA = 8'hA5;
  localparam int         NBEAT = 10000;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  dff_skid_slice #(.Width(W), .ResetData(RDATA)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO with capacity 2, tracked by write/read counts.
  logic [W-1:0] m_mem [256];
  int           m_wr = 0;
  int           m_rd = 0;
  int           m_size;
  logic         m_in_fire;
  logic         m_out_fire;

  assign m_size     = m_wr - m_rd;
  assign m_in_fire  = in_valid && (m_size < 2);
  assign m_out_fire = (m_size > 0) && out_ready;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_wr <= 0;
      m_rd <= 0;
    end else if (flush) begin
      m_rd <= m_wr;
    end else begin
      if (m_in_fire) begin
        m_mem[m_wr[7:0]] <= in_data;
        m_wr <= m_wr + 1;
      end
      if (m_out_fire) m_rd <= m_rd + 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_on && RSTN) begin
      chk("occupancy", {30'd0, occupancy}, m_size);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_size > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_size < 2});
      if (m_size > 0) chk("out_data", {24'd0, out_data}, {24'd0, m_mem[m_rd[7:0]]});
    end
  end

  // Scoreboard for the randomized phase.
  bit scb_on = 1'b0;
  int acc_cnt = 0;
  int emit_cnt = 0;
  always @(negedge CLK) begin
    if (scb_on && RSTN) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        chk("seq_data", {24'd0, out_data}, {24'd0, emit_cnt[7:0]});
        emit_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int idx;
    int cyc;

    // Reset asserted mid-cycle.
    #2 RSTN = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_occupancy", {30'd0, occupancy}, 0);
    chk("rst_out_data", {24'd0, out_data}, 32'hA5);
    step();
    RSTN = 1'b1;
    chk_on = 1'b1;
    step();

    // Streaming with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i[7:0];
      step();
      chk("stream_data", {24'd0, out_data}, i);
      chk("stream_occ", {30'd0, occupancy}, 1);
      chk("stream_ready", {31'd0, in_ready}, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", {30'd0, occupancy}, 0);

    // Backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    chk("bp_occ_full", {30'd0, occupancy}, 2);
    chk("bp_ready_low", {31'd0, in_ready}, 0);
    in_data = 8'h33;
    step();
    chk("bp_hold_data", {24'd0, out_data}, 32'h11);
    chk("bp_hold_occ", {30'd0, occupancy}, 2);
    out_ready = 1'b1;
    step();
    chk("bp_ready_back", {31'd0, in_ready}, 1);
    chk("bp_second", {24'd0, out_data}, 32'h22);
    step();
    chk("bp_third", {24'd0, out_data}, 32'h33);
    chk("bp_third_occ", {30'd0, occupancy}, 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 0);

    // Flush colliding with an incoming beat while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    step();
    in_data = 8'h55;
    step();
    chk("fl_full", {30'd0, occupancy}, 2);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_data   = 8'h66;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", {30'd0, occupancy}, 0);
    chk("fl_valid", {31'd0, out_valid}, 0);
    chk("fl_ready", {31'd0, in_ready}, 1);
    step();
    step();
    chk("fl_no_beat", {31'd0, out_valid}, 0);

    // Reset in the middle of operation.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    in_data = 8'h88;
    step();
    chk("mr_full", {30'd0, occupancy}, 2);
    in_valid = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 0);
    chk("mr_ready", {31'd0, in_ready}, 1);
    chk("mr_occ", {30'd0, occupancy}, 0);
    chk("mr_data", {24'd0, out_data}, 32'hA5);
    #2 RSTN = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("mr_new_data", {24'd0, out_data}, 32'h5A);
    chk("mr_new_occ", {30'd0, occupancy}, 1);
    out_ready = 1'b1;
    step();
    chk("mr_drained", {30'd0, occupancy}, 0);

    // Randomized valid/ready with ordered scoreboard.
    scb_on = 1'b1;
    idx = 0;
    cyc = 0;
    while (emit_cnt < NBEAT && cyc < 60000) begin
      out_ready = ($urandom_range(4) > 1);
      if (!in_valid && idx < NBEAT && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_data  = idx[7:0];
      end
      step();
      cyc++;
      if (in_valid && acc_cnt == idx + 1) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    scb_on = 1'b0;
    in_valid = 1'b0;
    chk("rand_beats_out", emit_cnt, NBEAT);
    chk("rand_beats_in", acc_cnt, NBEAT);
    step();
    chk("rand_final_occ", {30'd0, occupancy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dff_skid_slice.md
Name: dff_skid_slice

Overview:
- Consumer-side register slice: accepts a valid/ready stream from an upstream flop stage and re-presents it registered to a downstream reader.
- Two flop entries (main plus skid) hold full throughput while keeping in_ready a pure flop output, with no combinational ready path.
- Used between the enable-gated state flops of a NoC router stage and the next pipeline stage.

Parameters:
- Width, 8, payload bit width.
- ResetData, 0 (Width bits), value out_data takes during reset.

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both entries.
- in_valid  input  1  upstream data valid.
- in_data  input  Width  upstream payload.
- in_ready  output  1  slice can accept; registered.
- out_valid  output  1  main entry holds data; registered.
- out_data  output  Width  main entry payload; registered.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Reset (RSTN low, asynchronous): out_valid=0, in_ready=1, occupancy=0, out_data=ResetData, skid data=ResetData. Outputs hold these values until the first rising CLK edge after RSTN rises.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_valid and in_data must be held while in_ready=0. Slice holds out_valid and out_data stable until out_fire.
- Latency: data accepted at edge N appears on out_data after edge N (one cycle), unless the slice is in FULL.
- States, encoded by occupancy:
  - EMPTY (0): in_fire -> main<=in_data, BUSY. Else stay.
  - BUSY (1):
    - in_fire & out_fire -> main<=in_data, stay BUSY.
    - in_fire & !out_fire -> skid<=in_data, in_ready<=0, FULL.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> hold.
  - FULL (2): in_ready=0, so no in_fire. out_fire -> main<=skid, in_ready<=1, BUSY. Else hold.
- Ordering: strict FIFO; skid data is always younger than main data.
- Data flops load only on their load condition (enable-gated). Data is never cleared except by reset.
- flush: at the next edge forces EMPTY, in_ready=1, out_valid=0. Data registers keep stale values.
- Simultaneous flush and in_fire: flush wins and the beat is dropped. Simultaneous flush and out_fire: the beat counts as consumed, and the state is EMPTY after the edge.
- Reset mid-transfer discards both entries immediately.
- in_valid while in_ready=0 is ignored, with no side effects.
- occupancy is never 3. Reaching 3 is a design error.

Optional Feature:
- DFF_SKID_SLICE_XCHECK_EN defined: simulation-only checker. It reports an error on any rising CLK edge where any of the following is X/Z:
  - out_valid or in_ready, while RSTN is high;
  - out_data, while out_valid=1;
  - in_data, while in_fire.
- It also errors if in_data changes while in_valid=1 and in_ready=0.
- The checker is excluded under SYNTHESIS in all cases.
- Undefined: no checker logic; RTL is functionally identical.

Test Plan:
- Reset: assert RSTN=0 mid-cycle with ResetData=8'hA5 -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=8'hA5.
- Streaming: out_ready=1, send 8'h01..8'h08 back-to-back -> same values on out_data one cycle later each, occupancy=1 throughout, in_ready never 0.
- Backpressure: out_ready=0, send 8'h11 then 8'h22 -> occupancy=2, in_ready=0 and in_data=8'h33 held. Raise out_ready for one cycle -> out 8'h11, in_ready=1. Next cycles -> 8'h22 then 8'h33, in order, no loss or duplication.
- Flush collision: in FULL with out_ready=1, pulse flush together with in_valid=1 -> next edge occupancy=0, out_valid=0, in_ready=1, no beat emitted afterward.
- Reset mid-operation: occupancy=2, pull RSTN low for 3 ns -> all outputs at reset values. After release, send 8'h5A -> out_data=8'h5A with occupancy=1.
- Randomized valid/ready plus scoreboard over 10k beats -> output sequence equals input sequence, occupancy never exceeds 2.
